// File: rtl/simple_bus_master_if.sv
// Core-side command/response port and simple_bus request/grant signals.
// The shared data byte lane stays a plain inout on the engine, not in this bundle.
interface simple_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic        cmd_burst;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_error;
  logic [31:0] rsp_rdata;
  logic        req;
  logic        gnt;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  addr;
  logic        rdy;

  // Command: accepted on a cycle where cmd_valid && cmd_ready; fields must be stable that cycle.
  // Response: rsp_valid is a one-cycle pulse with no back-pressure; rsp_error/rsp_rdata qualify it.
  modport master (
    input  cmd_valid, cmd_write, cmd_burst, cmd_addr, cmd_wdata, gnt, rdy,
    output cmd_ready, rsp_valid, rsp_error, rsp_rdata, req, start, mode, addr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_burst, cmd_addr, cmd_wdata, gnt, rdy,
    input  cmd_ready, rsp_valid, rsp_error, rsp_rdata, req, start, mode, addr
  );
endinterface

// File: rtl/simple_bus_master.sv
// Transaction engine: runs req -> gnt -> start -> rdy-per-beat on simple_bus for one
// core command at a time, returning a single response with timeout/grant-loss errors.
module simple_bus_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  simple_bus_master_if.master bus,
  inout  wire  [7:0]          data,
  output logic [2:0]          o_dbg_state,
  output logic                o_dbg_data_oe
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_START = 3'd2,
    ST_XFER  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic        r_write;
  logic        r_burst;
  logic [7:0]  r_cmd_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_beat;
  logic [7:0]  r_tcnt;
  logic        r_cmd_ready;
  logic        r_req;
  logic        r_start;
  logic [1:0]  r_mode;
  logic [7:0]  r_addr;
  logic        r_rsp_valid;
  logic        r_rsp_error;
  logic [31:0] r_rdata;

  logic        w_last;
  logic        w_tmo;
  logic        w_abort;
  logic        w_done;
  logic        w_data_oe;
  logic [7:0]  w_wbyte;

  assign w_last  = (r_beat == (r_burst ? 2'd3 : 2'd0));
  assign w_tmo   = ((r_tcnt + 8'd1) == TMO);
  // Grant loss outranks a same-edge rdy; a same-edge rdy outranks the timeout.
  assign w_abort = (r_state == ST_REQ && !bus.gnt && w_tmo) ||
                   ((r_state == ST_START || r_state == ST_XFER) && !bus.gnt) ||
                   (r_state == ST_XFER && bus.gnt && !bus.rdy && w_tmo);
  assign w_done  = (r_state == ST_XFER) && bus.gnt && bus.rdy && w_last;

  assign w_data_oe = r_write && (r_state == ST_START || r_state == ST_XFER);
  assign w_wbyte   = r_wdata[{r_beat, 3'b000} +: 8];
  assign data      = w_data_oe ? w_wbyte : 8'hzz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_burst     <= 1'b0;
      r_cmd_addr  <= 8'h00;
      r_wdata     <= 32'h0;
      r_beat      <= 2'd0;
      r_tcnt      <= 8'h00;
      r_cmd_ready <= 1'b1;
      r_req       <= 1'b0;
      r_start     <= 1'b0;
      r_mode      <= 2'b00;
      r_addr      <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rdata     <= 32'h0;
    end else begin
      if (r_state == ST_XFER && bus.gnt && bus.rdy && !r_write)
        r_rdata[{r_beat, 3'b000} +: 8] <= data;

      if (w_abort || w_done) begin
        r_state     <= ST_RESP;
        r_req       <= 1'b0;
        r_start     <= 1'b0;
        r_mode      <= 2'b00;
        r_addr      <= 8'h00;
        r_rsp_valid <= 1'b1;
        r_rsp_error <= w_abort;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.cmd_valid) begin
              r_write     <= bus.cmd_write;
              r_burst     <= bus.cmd_burst;
              r_cmd_addr  <= bus.cmd_addr;
              r_wdata     <= bus.cmd_wdata;
              r_rdata     <= 32'h0;
              r_beat      <= 2'd0;
              r_tcnt      <= 8'h00;
              r_cmd_ready <= 1'b0;
              r_req       <= 1'b1;
              r_state     <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (bus.gnt) begin
              r_state <= ST_START;
              r_start <= 1'b1;
              r_mode  <= {r_burst, r_write};
              r_addr  <= r_cmd_addr;
              r_tcnt  <= 8'h00;
            end else begin
              r_tcnt <= r_tcnt + 8'd1;
            end
          end
          ST_START: begin
            r_state <= ST_XFER;
            r_start <= 1'b0;
          end
          ST_XFER: begin
            if (bus.rdy) begin
              r_beat <= r_beat + 2'd1;
              r_tcnt <= 8'h00;
            end else begin
              r_tcnt <= r_tcnt + 8'd1;
            end
          end
          ST_RESP: begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.req       = r_req;
  assign bus.start     = r_start;
  assign bus.mode      = r_mode;
  assign bus.addr      = r_addr;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_error = r_rsp_error;
  assign bus.rsp_rdata = r_rdata;
  assign o_dbg_state   = r_state;
  assign o_dbg_data_oe = w_data_oe;

endmodule

// File: tb/tb_simple_bus_master.sv
// Directed bench for simple_bus_master: expected responses are queued by the stimulus
// and popped by an independent response monitor; bus-level timing is checked inline.
module tb_simple_bus_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  simple_bus_master_if bus ();
  simple_bus_master_if bus_t ();

  wire  [7:0] bus_data;
  wire  [7:0] bus_data_t;
  logic       mem_oe;
  logic [7:0] mem_byte;
  assign bus_data = mem_oe ? mem_byte : 8'hzz;

  logic [2:0] dbg_state, dbg_state_t;
  logic       dbg_oe, dbg_oe_t;

  simple_bus_master dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.master),
    .data          (bus_data),
    .o_dbg_state   (dbg_state),
    .o_dbg_data_oe (dbg_oe)
  );

  simple_bus_master #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_t.master),
    .data          (bus_data_t),
    .o_dbg_state   (dbg_state_t),
    .o_dbg_data_oe (dbg_oe_t)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (!bus.cmd_ready && budget < 50) begin
      step();
      budget++;
    end
    chk("idle_wait", bus.cmd_ready, 1);
  endtask

  // Accepts one command, waits gnt_delay REQ cycles with gnt low, then walks START into XFER.
  task automatic issue(input logic w, input logic b, input logic [7:0] a,
                       input logic [31:0] wd, input int gnt_delay);
    wait_idle();
    bus.gnt       = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_burst = b;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    step();
    bus.cmd_valid = 1'b0;
    chk("req_rise", bus.req, 1);
    chk("cmd_ready_busy", bus.cmd_ready, 0);
    repeat (gnt_delay) begin
      step();
      chk("req_wait", bus.req, 1);
      chk("start_wait", bus.start, 0);
    end
    bus.gnt = 1'b1;
    step();
    chk("start_pulse", bus.start, 1);
    chk("start_mode", bus.mode, {b, w});
    chk("start_addr", bus.addr, a);
    chk("start_oe", dbg_oe, w);
    if (w) chk("start_data", bus_data, wd[7:0]);
    step();
    chk("start_one_cycle", bus.start, 0);
    chk("xfer_mode", bus.mode, {b, w});
    chk("xfer_addr", bus.addr, a);
  endtask

  // One beat: gap cycles with rdy low, then one cycle with rdy high (memory drives on reads).
  task automatic beat(input logic [7:0] b, input int gap, input logic wr);
    bus.rdy = 1'b0;
    repeat (gap) begin
      chk("xfer_oe", dbg_oe, wr);
      if (wr) chk("wr_hold", bus_data, b);
      step();
    end
    chk("xfer_oe", dbg_oe, wr);
    if (wr) chk("wr_beat", bus_data, b);
    bus.rdy = 1'b1;
    if (!wr) begin
      mem_oe   = 1'b1;
      mem_byte = b;
    end
    step();
    bus.rdy = 1'b0;
    mem_oe  = 1'b0;
  endtask

  task automatic resp_check();
    chk("resp_valid", bus.rsp_valid, 1);
    chk("resp_req", bus.req, 0);
    chk("resp_oe", dbg_oe, 0);
    chk("resp_mode", bus.mode, 0);
    chk("resp_addr", bus.addr, 0);
    step();
    chk("idle_ready", bus.cmd_ready, 1);
    chk("idle_rsp_low", bus.rsp_valid, 0);
  endtask

  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got err=%b rdata=%h, required no response",
                   bus.rsp_error, bus.rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_error", bus.rsp_error, e[32]);
          chk("rsp_rdata", bus.rsp_rdata, e[31:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    mem_oe = 1'b0;
    mem_byte = 8'h00;
    bus.cmd_valid = 1'b0;   bus.cmd_write = 1'b0;   bus.cmd_burst = 1'b0;
    bus.cmd_addr  = 8'h00;  bus.cmd_wdata = 32'h0;  bus.gnt = 1'b0;  bus.rdy = 1'b0;
    bus_t.cmd_valid = 1'b0; bus_t.cmd_write = 1'b0; bus_t.cmd_burst = 1'b0;
    bus_t.cmd_addr = 8'h00; bus_t.cmd_wdata = 32'h0; bus_t.gnt = 1'b0; bus_t.rdy = 1'b0;
    repeat (2) step();

    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_req", bus.req, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_mode", bus.mode, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_error", bus.rsp_error, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_oe", dbg_oe, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    step();

    // Single write, gnt two cycles after req, rdy the cycle after start.
    exp_q.push_back({1'b0, 32'h0});
    issue(1'b1, 1'b0, 8'h3C, 32'h000000A5, 2);
    beat(8'hA5, 0, 1'b1);
    resp_check();

    // Burst read with separated rdy beats.
    exp_q.push_back({1'b0, 32'h44332211});
    issue(1'b0, 1'b1, 8'h10, 32'h0, 0);
    beat(8'h11, 1, 1'b0);
    beat(8'h22, 1, 1'b0);
    beat(8'h33, 1, 1'b0);
    beat(8'h44, 1, 1'b0);
    chk("burst_rdata", bus.rsp_rdata, 32'h44332211);
    resp_check();
    chk("rdata_held", bus.rsp_rdata, 32'h44332211);

    // Burst write with rdy gaps 0,3,0,5.
    exp_q.push_back({1'b0, 32'h0});
    issue(1'b1, 1'b1, 8'hA0, 32'hDEADBEEF, 0);
    beat(8'hEF, 0, 1'b1);
    beat(8'hBE, 3, 1'b1);
    beat(8'hAD, 0, 1'b1);
    beat(8'hDE, 5, 1'b1);
    resp_check();

    // Grant lost on the same edge as the third beat's rdy: error wins, byte 2 stays 0.
    exp_q.push_back({1'b1, 32'h00006B5A});
    issue(1'b0, 1'b1, 8'h20, 32'h0, 1);
    beat(8'h5A, 0, 1'b0);
    beat(8'h6B, 0, 1'b0);
    bus.gnt  = 1'b0;
    bus.rdy  = 1'b1;
    mem_oe   = 1'b1;
    mem_byte = 8'h7C;
    step();
    bus.rdy = 1'b0;
    mem_oe  = 1'b0;
    chk("gl_rsp_valid", bus.rsp_valid, 1);
    chk("gl_rsp_error", bus.rsp_error, 1);
    chk("gl_req", bus.req, 0);
    chk("gl_rdata", bus.rsp_rdata, 32'h00006B5A);
    bus.gnt = 1'b1;
    step();

    // Grant timeout with TIMEOUT_CYCLES=4: four REQ cycles, then error response.
    bus_t.cmd_valid = 1'b1;
    bus_t.cmd_write = 1'b1;
    bus_t.cmd_addr  = 8'h55;
    step();
    bus_t.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("tmo_req", bus_t.req, 1);
      chk("tmo_no_start", bus_t.start, 0);
      chk("tmo_no_rsp", bus_t.rsp_valid, 0);
      step();
    end
    chk("tmo_rsp_valid", bus_t.rsp_valid, 1);
    chk("tmo_rsp_error", bus_t.rsp_error, 1);
    chk("tmo_req_low", bus_t.req, 0);
    step();

    // rdy on the edge where the XFER timeout would fire: beat completes without error.
    bus_t.gnt       = 1'b1;
    bus_t.cmd_valid = 1'b1;
    bus_t.cmd_write = 1'b0;
    bus_t.cmd_addr  = 8'h66;
    step();
    bus_t.cmd_valid = 1'b0;
    step();
    chk("tr_start", bus_t.start, 1);
    repeat (4) step();
    bus_t.rdy = 1'b1;
    chk("tr_still_xfer", bus_t.rsp_valid, 0);
    step();
    bus_t.rdy = 1'b0;
    chk("tr_rsp_valid", bus_t.rsp_valid, 1);
    chk("tr_rsp_error", bus_t.rsp_error, 0);
    bus_t.gnt = 1'b0;
    step();

    // Back-to-back with cmd_valid held; rdy high during START must be ignored.
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'h0});
    wait_idle();
    bus.gnt       = 1'b1;
    bus.rdy       = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_burst = 1'b0;
    bus.cmd_addr  = 8'h40;
    bus.cmd_wdata = 32'h00000077;
    step();
    chk("b2b_req", bus.req, 1);
    step();
    chk("b2b_start", bus.start, 1);
    step();
    chk("b2b_rdy_in_start_ignored", bus.rsp_valid, 0);
    step();
    chk("b2b_rsp1", bus.rsp_valid, 1);
    step();
    chk("b2b_idle_ready", bus.cmd_ready, 1);
    step();
    chk("b2b_second_accept", bus.req, 1);
    chk("b2b_second_busy", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b0;
    wait_idle();
    bus.rdy = 1'b0;
    step();
    chk("b2b_drained", exp_q.size(), 0);

    // Reset asserted mid-XFER of a burst write: silent abort.
    issue(1'b1, 1'b1, 8'h80, 32'h04030201, 0);
    chk("pre_rst_oe", dbg_oe, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", bus.req, 0);
    chk("arst_start", bus.start, 0);
    chk("arst_mode", bus.mode, 0);
    chk("arst_addr", bus.addr, 0);
    chk("arst_oe", dbg_oe, 0);
    chk("arst_state", dbg_state, 0);
    chk("arst_cmd_ready", bus.cmd_ready, 1);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("arst_no_rsp", bus.rsp_valid, 0);

    chk("final_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_bus_master.md
# simple_bus_master

CPU-side transaction engine that drives the `simple_bus` request/grant protocol into the memory module (`memMod`). It accepts one command at a time from a core-side valid/ready port and performs the bus sequence req → gnt → start → rdy-per-beat. It supports single-byte and 4-beat burst reads and writes. It returns one response per command, with timeout and grant-loss error detection.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, max consecutive cycles waiting for gnt or for rdy before abort (1..255, 8-bit counter)

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  bus clock, all logic on posedge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  engine idle, command accepted when cmd_valid&cmd_ready
- cmd_write  input  1  1=write, 0=read
- cmd_burst  input  1  1=4 beats, 0=1 beat
- cmd_addr  input  8  bus address
- cmd_wdata  input  32  write data, beat k = bits [8k+7:8k]
- rsp_valid  output  1  one-cycle response pulse
- rsp_error  output  1  qualifies rsp_valid: timeout or grant loss
- rsp_rdata  output  32  read data, beat k in [8k+7:8k], unused bytes 0
- req  output  1  bus request
- gnt  input  1  bus grant
- start  output  1  one-cycle transfer start strobe
- mode  output  2  {burst, write}
- addr  output  8  transfer address
- data  inout  8  shared data bus (wire)
- rdy  input  1  beat completion from memory

## Operation
- States: IDLE, REQ, START, XFER, RESP.
- IDLE: cmd_ready=1. On accept, latch write/burst/addr/wdata, clear rsp_rdata, clear beat counter and timeout counter, go to REQ.
- REQ: req=1. gnt sampled high → START. Timeout counter reaches TIMEOUT_CYCLES → RESP with error.
- START: req=1, start=1 for exactly one cycle, addr/mode driven. Always → XFER.
- XFER: req=1, addr/mode held.
  - rdy high: for a read, capture data into byte [beat]. Then, if beat==last (0 single, 3 burst) → RESP; else beat+1 and the timeout counter is cleared.
  - rdy low: timeout counter increments; reaching TIMEOUT_CYCLES → RESP with error.
- Grant loss: gnt low during START or XFER → RESP with error on the next edge.
- RESP: req=0, start=0. rsp_valid=1 for one cycle; rsp_error set if aborted. Always → IDLE.
- Data drive: data = wdata byte[beat] when write and state∈{START,XFER}; otherwise 8'hZZ. The byte switches on the edge after each rdy.
- mode, addr = 0 in IDLE and RESP.
- rdy outside XFER is ignored. gnt outside REQ/START/XFER is ignored.
- A cmd_valid during non-IDLE states is not accepted (cmd_ready=0).

## Timing
- Reset values (async, immediate): state IDLE, cmd_ready=1, req=0, start=0, mode=0, addr=0, rsp_valid=0, rsp_error=0, rsp_rdata=0, data=Z.
- Reset mid-transaction aborts silently: no response, and req drops asynchronously.
- All outputs are registered, except data enable (decoded from state/write/beat registers).
- Minimum latency, single beat, gnt and rdy already high:
  - accept edge at cycle 0
  - REQ cycle 1
  - START cycle 2
  - XFER cycle 3
  - rsp_valid cycle 4
  - cmd_ready high cycle 5
- Burst adds one cycle per extra beat minimum.
- Read data visible on rsp_rdata in the rsp_valid cycle and held until the next accept.
- rdy and start in the same cycle: rdy is ignored (START state).
- Timeout and rdy on the same edge: rdy wins (beat completes).
- Grant loss and rdy on the same edge: error wins.

## Test plan
- Single write:
  - Stimulus: addr=8'h3C, wdata=32'h000000A5; gnt high 2 cycles after req; rdy 1 cycle after start.
  - Required: start one cycle with mode=2'b01, addr=8'h3C; data=8'hA5 from START through rdy; rsp_valid, rsp_error=0; req low in RESP; data Z after.
- Burst read:
  - Stimulus: addr=8'h10; memory drives 8'h11,22,33,44 with rdy on 4 separated cycles.
  - Required: mode=2'b10; rsp_rdata=32'h44332211; exactly one rsp_valid; bus never driven by master.
- Burst write with rdy gaps of 0,3,0,5 cycles.
  - Required: data steps through wdata bytes 0..3, each held until its rdy; single rsp_valid, no error.
- Grant timeout:
  - Stimulus: TIMEOUT_CYCLES=4, gnt never asserted.
  - Required: rsp_valid with rsp_error=1 exactly 4 REQ cycles after req rises; start never pulses.
- Grant loss:
  - Stimulus: gnt dropped after beat 1 of a burst read.
  - Required: rsp_error=1 next cycle; rsp_rdata byte0 holds captured data, bytes 2–3 are 0.
- Back-to-back and reset:
  - cmd_valid held high across two commands → second accepted the cycle after RESP.
  - rst asserted in XFER → req, start, mode, addr immediately 0, data Z, no rsp_valid.
